// File: rtl/perm_cfg_sched_pkg.sv
// Shared definitions for the crossbar schedulers: scheduler state encoding
// and the lane-tag / control-word width derivations for a Benes network.
package perm_cfg_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // Bits needed to name one crossbar lane.
  function automatic int tag_width(input int size);
    return $clog2(size);
  endfunction

  // Control bits of a Benes network: 2*log2(size)-1 stages of size/2 switches.
  function automatic int ctrl_width(input int size);
    return (2 * $clog2(size) - 1) * size / 2;
  endfunction

endpackage

// File: rtl/perm_cfg_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first active request strictly after ptr,
// wrapping around once. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] cand;

  // Walk the requesters starting just after ptr and take the first one found.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_any   = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/perm_cfg_sched.sv
// Scheduler and configuration store for the Benes control-bit generator.
// Accepts one permutation job at a time, holds it on gen_perm for the whole
// generator latency, stores the result in a slot table and serves a
// registered control word for the selected slot.
module perm_cfg_sched
  import perm_cfg_sched_pkg::*;
#(
  parameter int  SIZE      = 32,
  parameter int  NUM_REQ   = 2,
  parameter int  NUM_SLOTS = 4,
  parameter int  GEN_LAT   = 2,
  localparam int TAGWIDTH  = tag_width(SIZE),
  localparam int BITWIDTH  = ctrl_width(SIZE),
  localparam int SLOTW     = $clog2(NUM_SLOTS),
  localparam int REQW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PERMW     = SIZE * TAGWIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*PERMW-1:0]   req_perm,
  input  logic [NUM_REQ*SLOTW-1:0]   req_slot,
  output logic [PERMW-1:0]           gen_perm,
  input  logic [BITWIDTH-1:0]        gen_ctrl,
  output logic                       done,
  output logic [REQW-1:0]            done_req,
  output logic [SLOTW-1:0]           done_slot,
  output logic                       busy,
  input  logic                       cfg_clear,
  output logic [NUM_SLOTS-1:0]       slot_valid,
  input  logic                       sel_en,
  input  logic [SLOTW-1:0]           sel_slot,
  output logic [BITWIDTH-1:0]        xbar_ctrl,
  output logic                       xbar_ctrl_valid
);

  localparam int CNTW = $clog2(GEN_LAT + 2);

  sched_state_t         state_r;
  sched_state_t         state_n;
  logic [CNTW-1:0]      cnt_r;
  logic [REQW-1:0]      rr_ptr_r;
  logic [PERMW-1:0]     perm_r;
  logic [SLOTW-1:0]     slot_r;
  logic [REQW-1:0]      req_r;
  logic [NUM_SLOTS-1:0] slot_valid_r;
  logic [NUM_SLOTS-1:0] slot_valid_n;
  logic                 done_r;
  logic [REQW-1:0]      done_req_r;
  logic [SLOTW-1:0]     done_slot_r;
  logic [BITWIDTH-1:0]  xbar_ctrl_r;
  logic                 xbar_ctrl_valid_r;
  logic [BITWIDTH-1:0]  table_r [NUM_SLOTS];

  logic [NUM_REQ-1:0]   gnt_s;
  logic [REQW-1:0]      gnt_idx_s;
  logic                 gnt_any_s;
  logic                 accept_s;
  logic                 capture_s;
  logic [PERMW-1:0]     acc_perm_s;
  logic [SLOTW-1:0]     acc_slot_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (REQW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  // Next-state and handshake decode; ready is forced low while reset is applied.
  always_comb begin
    state_n   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    req_ready = '0;
    case (state_r)
      IDLE: begin
        if (!rst && gnt_any_s) begin
          req_ready = gnt_s;
          accept_s  = 1'b1;
          state_n   = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (!rst && (cnt_r == CNTW'(GEN_LAT))) begin
          capture_s = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // One-hot mux of the granted requester's permutation and slot.
  always_comb begin
    acc_perm_s = '0;
    acc_slot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        acc_perm_s = acc_perm_s | req_perm[i*PERMW +: PERMW];
        acc_slot_s = acc_slot_s | req_slot[i*SLOTW +: SLOTW];
      end else begin
        acc_perm_s = acc_perm_s;
      end
    end
  end

  // Slot-valid update: clear-all first, then the accepted slot is invalidated,
  // and a capture sets its own bit last so it wins over a simultaneous clear.
  always_comb begin
    slot_valid_n = slot_valid_r;
    if (cfg_clear) begin
      slot_valid_n = '0;
    end else begin
      slot_valid_n = slot_valid_n;
    end
    if (accept_s) begin
      slot_valid_n[acc_slot_s] = 1'b0;
    end else begin
      slot_valid_n = slot_valid_n;
    end
    if (capture_s) begin
      slot_valid_n[slot_r] = 1'b1;
    end else begin
      slot_valid_n = slot_valid_n;
    end
  end

  // Control registers: FSM state, job latch, latency counter, status and read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      cnt_r             <= '0;
      rr_ptr_r          <= REQW'(NUM_REQ - 1);
      perm_r            <= '0;
      slot_r            <= '0;
      req_r             <= '0;
      slot_valid_r      <= '0;
      done_r            <= 1'b0;
      done_req_r        <= '0;
      done_slot_r       <= '0;
      xbar_ctrl_r       <= '0;
      xbar_ctrl_valid_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      slot_valid_r <= slot_valid_n;
      done_r       <= capture_s;
      if (accept_s) begin
        perm_r   <= acc_perm_s;
        slot_r   <= acc_slot_s;
        req_r    <= gnt_idx_s;
        rr_ptr_r <= gnt_idx_s;
        cnt_r    <= '0;
      end else if (state_r == RUN) begin
        cnt_r <= cnt_r + CNTW'(1);
      end
      if (capture_s) begin
        done_req_r  <= req_r;
        done_slot_r <= slot_r;
      end
      if (sel_en) begin
        xbar_ctrl_r       <= table_r[sel_slot];
        xbar_ctrl_valid_r <= slot_valid_r[sel_slot];
      end
    end
  end

  // Configuration table: written only at the capture edge, never reset.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      table_r[slot_r] <= gen_ctrl;
    end
  end

  assign gen_perm        = perm_r;
  assign done            = done_r;
  assign done_req        = done_req_r;
  assign done_slot       = done_slot_r;
  assign busy            = (state_r != IDLE);
  assign slot_valid      = slot_valid_r;
  assign xbar_ctrl       = xbar_ctrl_r;
  assign xbar_ctrl_valid = xbar_ctrl_valid_r;

endmodule

// File: tb/tb_perm_cfg_sched.sv
// Self-checking bench for perm_cfg_sched: directed scenarios followed by a
// randomized phase, all compared against a job-level reference model.
module tb_perm_cfg_sched;

  localparam int SIZE  = 32;
  localparam int NREQ  = 2;
  localparam int NSLOT = 4;
  localparam int GLAT  = 2;
  localparam int TW    = 5;
  localparam int BW    = 144;
  localparam int SW    = 2;
  localparam int PERMW = SIZE * TW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*PERMW-1:0] req_perm;
  logic [NREQ*SW-1:0]    req_slot;
  logic [PERMW-1:0]      gen_perm;
  logic [BW-1:0]         gen_ctrl;
  logic                  done;
  logic [0:0]            done_req;
  logic [SW-1:0]         done_slot;
  logic                  busy;
  logic                  cfg_clear;
  logic [NSLOT-1:0]      slot_valid;
  logic                  sel_en;
  logic [SW-1:0]         sel_slot;
  logic [BW-1:0]         xbar_ctrl;
  logic                  xbar_ctrl_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perm_cfg_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_perm(req_perm), .req_slot(req_slot), .gen_perm(gen_perm),
    .gen_ctrl(gen_ctrl), .done(done), .done_req(done_req),
    .done_slot(done_slot), .busy(busy), .cfg_clear(cfg_clear),
    .slot_valid(slot_valid), .sel_en(sel_en), .sel_slot(sel_slot),
    .xbar_ctrl(xbar_ctrl), .xbar_ctrl_valid(xbar_ctrl_valid)
  );

  function automatic logic [BW-1:0] golden(input logic [PERMW-1:0] p);
    return p[BW-1:0] ^ p[PERMW-1:PERMW-BW];
  endfunction

  // Generator stub: two stages, last stage also reads perm directly; any
  // change of gen_perm inside the window yields a corrupted word.
  logic [PERMW-1:0] s1, s2;
  always @(posedge clk) begin
    s1 <= gen_perm;
    s2 <= s1;
  end
  assign gen_ctrl = (s1 === gen_perm && s2 === gen_perm) ? golden(gen_perm) : ~golden(gen_perm);

  // Reference model state
  logic             m_busy = 1'b0;
  int               m_left, m_req, m_slot, m_ptr;
  logic [PERMW-1:0] m_perm;
  logic [NSLOT-1:0] m_sv;
  logic [BW-1:0]    m_tbl [NSLOT];
  logic             m_wr [NSLOT] = '{default: 1'b0};
  logic [BW-1:0]    m_x;
  logic             m_xv, m_xknown, m_done;
  int               m_done_req, m_done_slot;
  logic [NREQ-1:0]  m_ready;
  int               cyc_n = 0;
  int               grant_q[$];
  int               acc_q[$];
  int               done_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; cfg_clear = 1'b0; sel_en = 1'b0; rst = 1'b0;
  endtask

  // One clock cycle: inputs are already driven; check combinational outputs,
  // advance the model by one edge, then check registered outputs.
  task automatic cyc();
    int g;
    logic cap;
    #1;
    g = -1;
    m_ready = '0;
    if (!rst && !m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    if (g >= 0) m_ready[g] = 1'b1;
    check("req_ready", 256'(req_ready), 256'(m_ready));
    if (m_busy) check("gen_perm_hold", 256'(gen_perm), 256'(m_perm));
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        grant_q.push_back(i);
        acc_q.push_back(cyc_n);
      end
    end
    if (rst) begin
      m_busy = 1'b0; m_ptr = NREQ - 1; m_sv = '0; m_x = '0; m_xv = 1'b0;
      m_xknown = 1'b1; m_done = 1'b0;
    end else begin
      cap = m_busy && (m_left == 0);
      if (sel_en) begin
        m_x = m_tbl[sel_slot]; m_xv = m_sv[sel_slot]; m_xknown = m_wr[sel_slot];
      end
      m_done = cap;
      if (cap) begin m_done_req = m_req; m_done_slot = m_slot; end
      if (cfg_clear) m_sv = '0;
      if (cap) begin
        m_sv[m_slot] = 1'b1; m_tbl[m_slot] = golden(m_perm); m_wr[m_slot] = 1'b1;
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_left--;
      end
      if (g >= 0) begin
        m_busy = 1'b1; m_left = GLAT; m_req = g; m_ptr = g;
        m_slot = int'(req_slot[g*SW +: SW]);
        m_perm = req_perm[g*PERMW +: PERMW];
        m_sv[m_slot] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    check("done", 256'(done), 256'(m_done));
    check("busy", 256'(busy), 256'(m_busy));
    check("slot_valid", 256'(slot_valid), 256'(m_sv));
    check("xbar_ctrl_valid", 256'(xbar_ctrl_valid), 256'(m_xv));
    if (m_xknown) check("xbar_ctrl", 256'(xbar_ctrl), 256'(m_x));
    if (m_done) begin
      check("done_req", 256'(done_req), 256'(m_done_req));
      check("done_slot", 256'(done_slot), 256'(m_done_slot));
      done_q.push_back(int'(done_req));
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [PERMW-1:0] p, input int s);
    req_perm[r*PERMW +: PERMW] = p;
    req_slot[r*SW +: SW] = SW'(s);
  endtask

  function automatic logic [PERMW-1:0] rand_perm();
    logic [PERMW-1:0] p;
    for (int w = 0; w < PERMW / 32; w++) p[w*32 +: 32] = $urandom;
    return p;
  endfunction

  // Run a single-requester job to completion.
  task automatic job(input int r, input logic [PERMW-1:0] p, input int s);
    set_req(r, p, s);
    req_valid = '0;
    req_valid[r] = 1'b1;
    cyc();
    req_valid = '0;
    for (int n = 0; n < 8 && m_busy; n++) cyc();
  endtask

  logic [PERMW-1:0] ident, p1;

  initial begin
    idle_inputs();
    req_perm = '0; req_slot = '0; sel_slot = '0;

    // Reset with both requesters asserting: no grant during reset.
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    cyc(); cyc();
    idle_inputs();
    check("rst_gen_perm", 256'(gen_perm), 256'(0));
    check("rst_xbar_ctrl", 256'(xbar_ctrl), 256'(0));
    check("rst_slot_valid", 256'(slot_valid), 256'(0));

    // Single identity job from requester 0 into slot 2.
    for (int i = 0; i < SIZE; i++) ident[i*TW +: TW] = TW'(i);
    set_req(0, ident, 2);
    req_valid = 2'b01;
    #1;
    check("e0_ready", 256'(req_ready), 256'(2'b01));
    cyc();
    req_valid = '0;
    cyc(); cyc(); cyc();
    check("e3_done", 256'(done), 256'(1));
    check("e3_done_slot", 256'(done_slot), 256'(2));
    check("e3_slot_valid", 256'(slot_valid), 256'(4'b0100));
    sel_en = 1'b1; sel_slot = 2'd2;
    cyc();
    sel_en = 1'b0;
    check("read_slot2", 256'(xbar_ctrl), 256'(golden(ident)));
    check("read_slot2_valid", 256'(xbar_ctrl_valid), 256'(1));

    // Both requesters continuously valid: alternating grants every GLAT+2.
    grant_q.delete(); acc_q.delete(); done_q.delete();
    set_req(0, rand_perm(), 0);
    set_req(1, rand_perm(), 3);
    req_valid = 2'b11;
    for (int n = 0; n < 17; n++) cyc();
    req_valid = '0;
    for (int n = 0; n < 8 && m_busy; n++) cyc();
    check("alt_count", 256'(grant_q.size() >= 4), 256'(1));
    for (int i = 1; i < grant_q.size(); i++) begin
      check("alt_order", 256'(grant_q[i] != grant_q[i-1]), 256'(1));
      check("alt_spacing", 256'(acc_q[i] - acc_q[i-1]), 256'(GLAT + 2));
    end
    check("done_count", 256'(done_q.size()), 256'(grant_q.size()));
    for (int i = 0; i < done_q.size() && i < grant_q.size(); i++)
      check("done_req_order", 256'(done_q[i]), 256'(grant_q[i]));

    // cfg_clear coinciding with a capture to slot 1, plus read on that edge.
    job(0, rand_perm(), 0);
    job(1, rand_perm(), 3);
    p1 = rand_perm();
    set_req(0, p1, 1);
    req_valid = 2'b01;
    cyc();
    req_valid = '0;
    cyc(); cyc();
    cfg_clear = 1'b1; sel_en = 1'b1; sel_slot = 2'd1;
    cyc();
    cfg_clear = 1'b0;
    check("clear_vs_capture", 256'(slot_valid), 256'(4'b0010));
    check("read_on_capture_valid", 256'(xbar_ctrl_valid), 256'(0));
    cyc();
    sel_en = 1'b0;
    check("read_after_capture_valid", 256'(xbar_ctrl_valid), 256'(1));
    check("read_after_capture_word", 256'(xbar_ctrl), 256'(golden(p1)));

    // Reset during RUN at cnt=1 drops the job.
    set_req(1, rand_perm(), 2);
    req_valid = 2'b10;
    cyc();
    req_valid = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_run_done", 256'(done), 256'(0));
    check("rst_run_busy", 256'(busy), 256'(0));
    check("rst_run_slot_valid", 256'(slot_valid), 256'(0));
    req_valid = 2'b11;
    #1;
    check("rst_run_first_grant", 256'(req_ready), 256'(2'b01));
    cyc();
    req_valid = '0;
    for (int n = 0; n < 8 && m_busy; n++) cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom_range(0, 3));
      for (int r = 0; r < NREQ; r++) set_req(r, rand_perm(), int'($urandom_range(0, NSLOT - 1)));
      cfg_clear = ($urandom_range(0, 7) == 0);
      sel_en    = $urandom_range(0, 1) == 1;
      sel_slot  = SW'($urandom_range(0, NSLOT - 1));
      rst       = ($urandom_range(0, 63) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
